// File: rtl/sram_mmu_pkg.sv
// Shared definitions for the paged SRAM controller: FSM states, I/O port
// offsets within the block's port window and the reset page mapping.
package sram_mmu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } mmu_state_t;

    localparam int NUM_PAGES = 4;

    localparam logic [2:0] IO_PAGE0 = 3'd0;
    localparam logic [2:0] IO_PAGE1 = 3'd1;
    localparam logic [2:0] IO_PAGE2 = 3'd2;
    localparam logic [2:0] IO_PAGE3 = 3'd3;
    localparam logic [2:0] IO_CTRL  = 3'd4;

    localparam int CTRL_ROM_DIS = 0;

    // Out of reset the CPU sees an identity map of the first 64 KB of SRAM.
    function automatic logic [7:0] pageResetValue(input int unsigned idx);
        return 8'(idx);
    endfunction

endpackage

// File: rtl/sram_mmu_pages.sv
// Page register file and ROM overlay latch, written and read through the
// block's I/O port window. Writes land once per I/O write strobe.
module sram_mmu_pages
    import sram_mmu_pkg::*;
#(
    parameter int         PAGE_BITS = 4,
    parameter logic [7:0] IO_BASE   = 8'h78
) (
    input  logic                                 clk,
    input  logic                                 n_reset,
    input  logic [7:0]                           i_ioAddr,
    input  logic                                 i_nIorq,
    input  logic                                 i_nRd,
    input  logic                                 i_nWr,
    input  logic [PAGE_BITS-1:0]                 i_pageData,
    input  logic                                 i_ctrlRomDis,
    output logic [NUM_PAGES-1:0][PAGE_BITS-1:0]  o_pages,
    output logic                                 o_romEn,
    output logic                                 o_ioCs,
    output logic [7:0]                           o_ioDout
);

    logic [NUM_PAGES-1:0][PAGE_BITS-1:0] r_pages;
    logic                                r_romEn;
    logic                                r_nWrPrev;
    logic                                w_ioSel;
    logic                                w_wrStrobe;

    assign w_ioSel    = !i_nIorq && (i_ioAddr[7:3] == IO_BASE[7:3]) && (i_ioAddr[2:0] <= IO_CTRL);
    assign w_wrStrobe = w_ioSel && !i_nWr && r_nWrPrev;

    assign o_pages = r_pages;
    assign o_romEn = r_romEn;
    assign o_ioCs  = w_ioSel && !i_nRd;

    // Register file update on the first clock of each I/O write strobe.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_nWrPrev <= 1'b1;
            r_romEn   <= 1'b1;
            for (int i = 0; i < NUM_PAGES; i++) begin
                r_pages[i] <= PAGE_BITS'(pageResetValue(i));
            end
        end else begin
            r_nWrPrev <= i_nWr;
            if (w_wrStrobe) begin
                case (i_ioAddr[2:0])
                    IO_PAGE0, IO_PAGE1, IO_PAGE2, IO_PAGE3: r_pages[i_ioAddr[1:0]] <= i_pageData;
                    IO_CTRL: if (i_ctrlRomDis) r_romEn <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // Readback mux: page registers zero-extended, control shows the ROM latch.
    always_comb begin
        o_ioDout = 8'h00;
        case (i_ioAddr[2:0])
            IO_PAGE0, IO_PAGE1, IO_PAGE2, IO_PAGE3: o_ioDout = 8'(r_pages[i_ioAddr[1:0]]);
            IO_CTRL: o_ioDout = {7'b0, r_romEn};
            default: o_ioDout = 8'h00;
        endcase
    end

endmodule

// File: rtl/sram_mmu.sv
// Paged SRAM controller: maps Z80 addresses through four page registers,
// handles the boot ROM overlay and sequences CS/OE/WE with wait states,
// holding the CPU on wait_n until the SRAM cycle has completed.
module sram_mmu
    import sram_mmu_pkg::*;
#(
    parameter int         WAIT_STATES = 2,
    parameter int         PAGE_BITS   = 4,
    parameter logic [7:0] IO_BASE     = 8'h78
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic [15:0]             cpu_addr,
    input  logic [7:0]              cpu_dout,
    input  logic                    n_mreq,
    input  logic                    n_iorq,
    input  logic                    n_rd,
    input  logic                    n_wr,
    input  logic [7:0]              sram_rdata,
    output logic                    wait_n,
    output logic                    rom_sel,
    output logic [7:0]              mem_dout,
    output logic                    io_cs,
    output logic [7:0]              io_dout,
    output logic [PAGE_BITS+13:0]   sram_addr,
    output logic [7:0]              sram_wdata,
    output logic                    sram_drive,
    output logic                    n_sram_cs,
    output logic                    n_sram_oe,
    output logic                    n_sram_we
);

    localparam int             CW         = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CW-1:0]  LAST_COUNT = CW'(WAIT_STATES - 1);

    mmu_state_t                           r_state;
    mmu_state_t                           w_nextState;
    logic [PAGE_BITS+13:0]                r_addr;
    logic [7:0]                           r_wdata;
    logic                                 r_write;
    logic [CW-1:0]                        r_count;
    logic [7:0]                           r_memDout;
    logic [NUM_PAGES-1:0][PAGE_BITS-1:0]  w_pages;
    logic                                 w_romEn;
    logic                                 w_mreq;
    logic                                 w_romHit;
    logic                                 w_sramReq;
    logic                                 w_lastStrobe;

    sram_mmu_pages #(
        .PAGE_BITS (PAGE_BITS),
        .IO_BASE   (IO_BASE)
    ) u_pages (
        .clk          (clk),
        .n_reset      (n_reset),
        .i_ioAddr     (cpu_addr[7:0]),
        .i_nIorq      (n_iorq),
        .i_nRd        (n_rd),
        .i_nWr        (n_wr),
        .i_pageData   (cpu_dout[PAGE_BITS-1:0]),
        .i_ctrlRomDis (cpu_dout[CTRL_ROM_DIS]),
        .o_pages      (w_pages),
        .o_romEn      (w_romEn),
        .o_ioCs       (io_cs),
        .o_ioDout     (io_dout)
    );

    assign w_mreq       = !n_mreq && (!n_rd || !n_wr);
    assign w_romHit     = w_romEn && (cpu_addr[15:13] == 3'b000) && !n_rd;
    assign w_sramReq    = w_mreq && !w_romHit;
    assign w_lastStrobe = (r_count == LAST_COUNT);

    assign rom_sel    = w_mreq && w_romHit;
    assign wait_n     = !n_reset || !(w_sramReq && (r_state != ST_DONE));
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign mem_dout   = r_memDout;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and SRAM strobes; a dropped request cuts the strobe short.
    always_comb begin
        w_nextState = r_state;
        n_sram_cs   = 1'b1;
        n_sram_oe   = 1'b1;
        n_sram_we   = 1'b1;
        sram_drive  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sramReq) w_nextState = ST_SETUP;
            end
            ST_SETUP: begin
                n_sram_cs  = 1'b0;
                n_sram_oe  = r_write;
                sram_drive = r_write;
                w_nextState = w_sramReq ? ST_STROBE : ST_HOLD;
            end
            ST_STROBE: begin
                n_sram_cs  = 1'b0;
                n_sram_oe  = r_write;
                n_sram_we  = !r_write;
                sram_drive = r_write;
                if (!w_sramReq || w_lastStrobe) w_nextState = ST_HOLD;
            end
            ST_HOLD: begin
                n_sram_cs  = 1'b0;
                sram_drive = r_write;
                w_nextState = ST_DONE;
            end
            ST_DONE: begin
                if (!w_sramReq) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Cycle datapath: latch address/data at start, count wait states, capture read data.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_addr    <= '0;
            r_wdata   <= 8'h00;
            r_write   <= 1'b0;
            r_count   <= '0;
            r_memDout <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sramReq) begin
                        r_addr  <= {w_pages[cpu_addr[15:14]], cpu_addr[13:0]};
                        r_write <= !n_wr;
                        r_wdata <= cpu_dout;
                    end
                end
                ST_SETUP: r_count <= '0;
                ST_STROBE: begin
                    if (w_sramReq && w_lastStrobe) begin
                        if (!r_write) r_memDout <= sram_rdata;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mmu.sv
// Randomised bench for sram_mmu: an address-map / memory-contents model
// predicts every SRAM address, strobe length and readback value.
module tb_sram_mmu;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        n_mreq, n_iorq, n_rd, n_wr;
    logic [7:0]  sram_rdata;
    logic        wait_n, rom_sel, io_cs, sram_drive, n_sram_cs, n_sram_oe, n_sram_we;
    logic [7:0]  mem_dout, io_dout, sram_wdata;
    logic [17:0] sram_addr;

    int vecCount  = 0;
    int missCount = 0;

    int          refPage [4];
    bit          refRomEn;
    logic [7:0]  refMem [int];
    logic [7:0]  devMem [int];

    int          pendAddr;
    logic [7:0]  pendData;
    bit          pendValid = 0;

    sram_mmu #(.WAIT_STATES(WS), .PAGE_BITS(4), .IO_BASE(8'h78)) dut (
        .clk(clk), .n_reset(n_reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .n_mreq(n_mreq), .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr),
        .sram_rdata(sram_rdata), .wait_n(wait_n), .rom_sel(rom_sel),
        .mem_dout(mem_dout), .io_cs(io_cs), .io_dout(io_dout),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_drive(sram_drive),
        .n_sram_cs(n_sram_cs), .n_sram_oe(n_sram_oe), .n_sram_we(n_sram_we)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] defaultByte(input int a);
        return 8'((a * 7) ^ (a >> 8));
    endfunction

    function automatic logic [7:0] readRef(input int a);
        return refMem.exists(a) ? refMem[a] : defaultByte(a);
    endfunction

    function automatic logic [7:0] readDev(input int a);
        return devMem.exists(a) ? devMem[a] : defaultByte(a);
    endfunction

    function automatic int mapAddr(input int a);
        return refPage[a / 16384] * 16384 + (a % 16384);
    endfunction

    // Asynchronous SRAM stand-in: commits a write when WE rises, drives data while OE is low.
    always @(posedge clk) begin
        if (!n_sram_cs && !n_sram_we) begin
            pendValid = 1;
            pendAddr  = int'(sram_addr);
            pendData  = sram_wdata;
        end else if (pendValid && n_sram_we) begin
            devMem[pendAddr] = pendData;
            pendValid = 0;
        end
        #1;
        sram_rdata = (!n_sram_cs && !n_sram_oe) ? readDev(int'(sram_addr)) : 8'h00;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic releaseBus();
        n_mreq = 1'b1;
        n_iorq = 1'b1;
        n_rd   = 1'b1;
        n_wr   = 1'b1;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 4; i++) refPage[i] = i;
        refRomEn = 1'b1;
    endtask

    // One CPU memory access, held until the controller releases wait_n.
    task automatic memAccess(input bit isWrite, input logic [15:0] a, input logic [7:0] d);
        int   waitLow = 0, weLow = 0, oeLow = 0, csLow = 0, driveHigh = 0, wdataBad = 0, cycles = 0;
        bit   romHit, done;
        int   expAddr;
        logic [17:0] addrSeen;
        done     = 0;
        addrSeen = '0;
        romHit   = refRomEn && (a < 16'h2000) && !isWrite;
        expAddr  = mapAddr(int'(a));
        cpu_addr = a;
        cpu_dout = d;
        n_mreq   = 1'b0;
        n_rd     = isWrite;
        n_wr     = !isWrite;
        #1;
        checkOutput($sformatf("rom_sel@%h", a), 32'(rom_sel), 32'(romHit));
        while (!done && cycles < 16) begin
            @(negedge clk);
            cycles++;
            if (!wait_n) waitLow++;
            if (!n_sram_we) begin
                weLow++;
                if (sram_wdata !== d) wdataBad++;
            end
            if (!n_sram_oe) oeLow++;
            if (!n_sram_cs) begin
                csLow++;
                addrSeen = sram_addr;
            end
            if (sram_drive) driveHigh++;
            if (wait_n && (romHit || csLow > 0)) done = 1;
        end
        checkOutput($sformatf("complete@%h", a), 32'(done), 32'd1);
        if (romHit) begin
            checkOutput("rom_no_cs", csLow, 0);
            checkOutput("rom_no_wait", waitLow, 0);
        end else begin
            checkOutput($sformatf("addr@%h", a), 32'(addrSeen), expAddr);
            checkOutput("wait_len", waitLow, WS + 2);
            checkOutput("cs_len", csLow, WS + 2);
            checkOutput("we_len", weLow, isWrite ? WS : 0);
            checkOutput("oe_len", oeLow, isWrite ? 0 : WS + 1);
            checkOutput("drive_len", driveHigh, isWrite ? WS + 2 : 0);
            if (isWrite) begin
                checkOutput("wdata", wdataBad, 0);
                refMem[expAddr] = d;
            end else begin
                checkOutput($sformatf("rdata@%h", a), 32'(mem_dout), 32'(readRef(expAddr)));
            end
        end
        releaseBus();
        @(negedge clk);
        checkOutput("idle_cs", 32'(n_sram_cs), 32'd1);
    endtask

    // I/O write held for three clocks with the data bus changing mid-strobe.
    task automatic ioWrite(input logic [7:0] port, input logic [7:0] d);
        cpu_addr = {8'h00, port};
        cpu_dout = d;
        n_iorq   = 1'b0;
        n_wr     = 1'b0;
        @(negedge clk);
        cpu_dout = ~d;
        @(negedge clk);
        @(negedge clk);
        releaseBus();
        @(negedge clk);
        if (port >= 8'h78 && port <= 8'h7B) refPage[port - 8'h78] = int'(d & 8'h0F);
        else if (port == 8'h7C && d[0]) refRomEn = 1'b0;
    endtask

    task automatic ioRead(input logic [7:0] port);
        bit sel;
        int expVal;
        sel = (port >= 8'h78) && (port <= 8'h7C);
        expVal = (port == 8'h7C) ? int'(refRomEn) : (sel ? refPage[port - 8'h78] : 0);
        cpu_addr = {8'h00, port};
        n_iorq   = 1'b0;
        n_rd     = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("io_cs@%h", port), 32'(io_cs), 32'(sel));
        if (sel) checkOutput($sformatf("io_dout@%h", port), 32'(io_dout), expVal);
        releaseBus();
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        int op;
        logic [7:0]  port, d;
        logic [15:0] a;
        for (int n = 0; n < 80; n++) begin
            op = int'($urandom_range(0, 3));
            a  = 16'($urandom_range(0, 65535));
            d  = 8'($urandom);
            port = 8'($urandom_range(8'h76, 8'h7F));
            if (op == 2 && port == 8'h7C && ($urandom_range(0, 3) != 0)) d[0] = 1'b0;
            case (op)
                0: memAccess(1'b0, a, d);
                1: memAccess(1'b1, a, d);
                2: ioWrite(port, d);
                default: ioRead(port);
            endcase
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   weFalls;
        bit   prevWe;
        int   lostAddr;
        releaseBus();
        n_reset    = 1'b0;
        cpu_addr   = 16'h0000;
        cpu_dout   = 8'h00;
        sram_rdata = 8'h00;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("rst_cs", 32'(n_sram_cs), 32'd1);
        checkOutput("rst_oe", 32'(n_sram_oe), 32'd1);
        checkOutput("rst_we", 32'(n_sram_we), 32'd1);
        checkOutput("rst_drive", 32'(sram_drive), 32'd0);
        checkOutput("rst_wait", 32'(wait_n), 32'd1);
        checkOutput("rst_mem_dout", 32'(mem_dout), 32'd0);
        n_reset = 1'b1;
        @(negedge clk);
        for (int p = 8'h78; p <= 8'h7C; p++) ioRead(8'(p));

        memAccess(1'b0, 16'h0100, 8'h00);
        memAccess(1'b1, 16'h4123, 8'h5A);
        checkOutput("plan_wr_addr", 32'(sram_addr), 32'h04123);

        ioWrite(8'h7A, 8'h0F);
        refMem[32'h3C000] = 8'hC3;
        devMem[32'h3C000] = 8'hC3;
        memAccess(1'b0, 16'h8000, 8'h00);
        checkOutput("plan_rd_addr", 32'(sram_addr), 32'h3C000);
        checkOutput("plan_rd_data", 32'(mem_dout), 32'hC3);
        ioRead(8'h7A);

        ioWrite(8'h7C, 8'h01);
        memAccess(1'b0, 16'h0010, 8'h00);
        checkOutput("plan_rom_off_addr", 32'(sram_addr), 32'h00010);
        ioRead(8'h7C);

        // Reset in the middle of a write: strobes must collapse immediately.
        lostAddr = mapAddr(32'h4567);
        cpu_addr = 16'h4567;
        cpu_dout = 8'hA5;
        n_mreq   = 1'b0;
        n_wr     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_in_strobe", 32'(n_sram_we), 32'd0);
        n_reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_we", 32'(n_sram_we), 32'd1);
        checkOutput("abort_cs", 32'(n_sram_cs), 32'd1);
        checkOutput("abort_drive", 32'(sram_drive), 32'd0);
        checkOutput("abort_wait", 32'(wait_n), 32'd1);
        releaseBus();
        @(negedge clk);
        n_reset = 1'b1;
        modelReset();
        refMem[lostAddr] = 8'hA5;
        @(negedge clk);
        for (int p = 8'h78; p <= 8'h7C; p++) ioRead(8'(p));

        // A write strobe held far longer than the SRAM cycle.
        cpu_addr = 16'h4000;
        cpu_dout = 8'h3C;
        n_mreq   = 1'b0;
        n_wr     = 1'b0;
        weFalls  = 0;
        prevWe   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!n_sram_we && prevWe) weFalls++;
            prevWe = n_sram_we;
        end
        checkOutput("long_we_pulses", weFalls, 1);
        checkOutput("long_wait", 32'(wait_n), 32'd1);
        checkOutput("long_cs", 32'(n_sram_cs), 32'd1);
        releaseBus();
        refMem[mapAddr(32'h4000)] = 8'h3C;
        @(negedge clk);
        memAccess(1'b0, 16'h4000, 8'h00);

        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
